// File: rtl/softmax_pkg.sv
// Shared softmax types and constants.
// Q6.10 signed fixed point: DATA_W total bits, FRAC_W fractional bits.
package softmax_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 10;

  typedef logic signed [DATA_W-1:0] q_t;

  // Most negative Q6.10 value (-32.0).
  localparam q_t Q_MIN   = q_t'(16'h8000);
  // Underflow clamp level (-16.0); below this 2^y vanishes in Q6.10 anyway.
  localparam q_t Q_CLAMP = -q_t'(32'd16 << FRAC_W);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/log2e_scale.sv
// Combinational y = sat((x - max) * log2e), with log2e ~ 1 + 1/2 - 1/16.
// Ports:
//   x      - element being emitted (Q6.10)
//   max_v  - row maximum (Q6.10), so x - max_v <= 0
//   y      - scaled, saturated result (Q6.10, <= 0)
// Optional macro STAGE2_UNDERFLOW_CLAMP_EN: results below -16.0 clamp to -16.0.
module log2e_scale
  import softmax_pkg::*;
(
  input  q_t x,
  input  q_t max_v,
  output q_t y
);

  localparam int unsigned D_W = DATA_W + 1;
  localparam int unsigned S_W = DATA_W + 3;

  logic signed [D_W-1:0] d;
  logic signed [S_W-1:0] d_w;
  logic signed [S_W-1:0] y_w;

  // Difference, shift-add scale (floor shifts), then saturation.
  always_comb begin
    d   = D_W'(x) - D_W'(max_v);
    d_w = S_W'(d);
    y_w = d_w + (d_w >>> 1) - (d_w >>> 4);
    if (y_w < S_W'(Q_MIN)) begin
      y = Q_MIN;
    end else begin
      y = q_t'(y_w[DATA_W-1:0]);
    end
`ifdef STAGE2_UNDERFLOW_CLAMP_EN
    if (y_w < S_W'(Q_CLAMP)) begin
      y = Q_CLAMP;
    end
`endif
  end

endmodule

// File: rtl/stage2_max_sub_log2e.sv
// Softmax stage 2: buffer one row of VEC_LEN Q6.10 logits while tracking the
// row maximum, then replay it as (x - max) * log2e for the pow2 stage.
// Ports:
//   i_clk, i_rst_n    - clock, async active-low reset
//   i_en              - global enable; low freezes all state
//   i_valid, o_ready  - element handshake (o_ready only in COLLECT)
//   i_x               - input logit
//   o_valid, o_x      - scaled exponent stream (always <= 0)
//   o_x_byp           - original x alongside each result
//   o_last            - final element of a row
//   o_max             - row maximum, updated when a row enters EMIT
// Optional macro STAGE2_UNDERFLOW_CLAMP_EN (see log2e_scale).
module stage2_max_sub_log2e
  import softmax_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_x,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_x_byp,
  output logic              o_last,
  output logic [DATA_W-1:0] o_max
);

  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  q_t               max_q;
  q_t               buf_q [VEC_LEN];

  q_t   x_in;
  q_t   max_nxt;
  q_t   buf_rd;
  q_t   y;
  logic accept;
  logic idx_last;

  assign x_in     = q_t'(i_x);
  assign o_ready  = (state_q == COLLECT) & i_en;
  assign accept   = o_ready & i_valid;
  assign idx_last = (idx_q == IDX_LAST);
  // First element seeds the max; later ones keep the larger value.
  assign max_nxt  = ((idx_q == '0) || (x_in > max_q)) ? x_in : max_q;
  assign buf_rd   = buf_q[idx_q];

  log2e_scale u_scale (
    .x     (buf_rd),
    .max_v (max_q),
    .y     (y)
  );

  // Row buffer: data only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_q[idx_q] <= x_in;
    end
  end

  // Collect/emit FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      max_q   <= Q_MIN;
      o_valid <= 1'b0;
      o_x     <= '0;
      o_x_byp <= '0;
      o_last  <= 1'b0;
      o_max   <= '0;
    end else if (i_en) begin
      case (state_q)
        COLLECT: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (accept) begin
            max_q <= max_nxt;
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= EMIT;
              o_max   <= max_nxt;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        EMIT: begin
          o_valid <= 1'b1;
          o_x     <= y;
          o_x_byp <= buf_rd;
          o_last  <= idx_last;
          if (idx_last) begin
            idx_q   <= '0;
            state_q <= COLLECT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_stage2_max_sub_log2e.sv
// Scoreboard bench for stage2_max_sub_log2e with VEC_LEN=4 and hand-computed rows.
module tb_stage2_max_sub_log2e;

`ifdef STAGE2_UNDERFLOW_CLAMP_EN
  localparam logic [15:0] SAT = 16'hC000;
`else
  localparam logic [15:0] SAT = 16'h8000;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic [15:0] out_x;
  logic [15:0] out_byp;
  logic        out_last;
  logic [15:0] out_max;

  typedef struct {
    logic [15:0] y;
    logic [15:0] byp;
    logic [15:0] mx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  stage2_max_sub_log2e #(.VEC_LEN(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_valid (in_valid),
    .o_ready (ready),
    .i_x     (in_x),
    .o_valid (out_valid),
    .o_x     (out_x),
    .o_x_byp (out_byp),
    .o_last  (out_last),
    .o_max   (out_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one element (after optional idle gap) until accepted; returns at the next negedge.
  task automatic push_elem(input logic [15:0] x, input logic [15:0] y, input logic [15:0] mx,
                           input bit last, input int gap, input bit track);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_x     = x;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("accept_timeout", 16'd0, 16'd1);
    if (track) sb.push_back('{y: y, byp: x, mx: mx, last: last});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_row(input logic [15:0] xs [4], input logic [15:0] ys [4],
                          input logic [15:0] mx, input int gap);
    for (int k = 0; k < 4; k++) begin
      push_elem(xs[k], ys[k], mx, (k == 3), gap, 1'b1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("drain_timeout", 16'(sb.size()), 16'd0);
  endtask

  // Monitor: compare every newly registered output element (skip frozen edges).
  initial begin
    bit   en_s;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s = en;
      #1;
      if (rst_n && en_s && out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_x, 16'hxxxx);
        end else begin
          e = sb.pop_front();
          check("o_x", out_x, e.y);
          check("o_x_byp", out_byp, e.byp);
          check("o_last", 16'(out_last), 16'(e.last));
          check("o_max", out_max, e.mx);
        end
      end
    end
  end

  logic [15:0] xs [4];
  logic [15:0] ys [4];

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_x     = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_o_valid", 16'(out_valid), 16'd0);
    check("rst_o_x", out_x, 16'h0000);
    check("rst_o_max", out_max, 16'h0000);
    check("rst_o_last", 16'(out_last), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_o_ready", 16'(ready), 16'd1);

    // Basic row with latency profile.
    xs = '{16'h0400, 16'h0800, 16'h0200, 16'hFC00};
    ys = '{16'hFA40, 16'h0000, 16'hF760, 16'hEEC0};
    send_row(xs, ys, 16'h0800, 0);
    in_valid = 1'b0;
    check("lat_valid_E", 16'(out_valid), 16'd0);
    check("lat_ready_E", 16'(ready), 16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("lat_valid", 16'(out_valid), 16'd1);
      check("lat_ready", 16'(ready), (k == 4) ? 16'd1 : 16'd0);
    end
    @(negedge clk);
    check("lat_valid_end", 16'(out_valid), 16'd0);
    check("lat_last_end", 16'(out_last), 16'd0);
    wait_drain();

    // Saturation.
    xs = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    ys = '{16'h0000, SAT, 16'h0000, 16'h0000};
    send_row(xs, ys, 16'h7FFF, 0);
    in_valid = 1'b0;
    wait_drain();

    // All-equal row.
    xs = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    ys = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    send_row(xs, ys, 16'hFF00, 0);
    in_valid = 1'b0;
    wait_drain();

    // Gapped accepts, then a second row with valid held high through EMIT.
    xs = '{16'h0000, 16'h0100, 16'hFF00, 16'h0C00};
    ys = '{16'hEEC0, 16'hF030, 16'hED50, 16'h0000};
    send_row(xs, ys, 16'h0C00, 2);
    xs = '{16'h1000, 16'h2000, 16'h1800, 16'h0000};
    ys = '{16'hE900, 16'h0000, 16'hF480, 16'hD200};
    send_row(xs, ys, 16'h2000, 0);
    in_valid = 1'b0;
    wait_drain();

    // Enable freeze after the first emitted element.
    xs = '{16'h0400, 16'h0800, 16'h0200, 16'hFC00};
    ys = '{16'hFA40, 16'h0000, 16'hF760, 16'hEEC0};
    send_row(xs, ys, 16'h0800, 0);
    in_valid = 1'b0;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("frz_o_valid", 16'(out_valid), 16'd1);
      check("frz_o_x", out_x, 16'hFA40);
      check("frz_o_x_byp", out_byp, 16'h0400);
      check("frz_o_ready", 16'(ready), 16'd0);
    end
    en = 1'b1;
    wait_drain();
    repeat (2) @(negedge clk);

    // Async reset after two accepts; pre-reset data must not influence the next row.
    push_elem(16'h7000, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    push_elem(16'h7800, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_o_valid", 16'(out_valid), 16'd0);
    check("arst_o_x", out_x, 16'h0000);
    check("arst_o_x_byp", out_byp, 16'h0000);
    check("arst_o_max", out_max, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs = '{16'h0400, 16'h0800, 16'h0200, 16'hFC00};
    ys = '{16'hFA40, 16'h0000, 16'hF760, 16'hEEC0};
    send_row(xs, ys, 16'h0800, 0);
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
